// File: rtl/fetch_npc.sv
// Fetch next-PC select and IF/ID register for the five-stage MIPS core.
// Optional fetch address check enabled by FETCH_ALIGN_CHECK_EN.
module fetch_npc (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  PC_sel,
  input  logic        bw,
  input  logic        flush,
  input  logic [31:0] rs_D,
  input  logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        adel_F
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_pc;
  logic [31:0] j_pc;
  logic [31:0] next_pc;
  logic        nop_D;

  assign seq_pc = PC_F + 32'd4;
  assign br_off = {{14{instr_D[15]}}, instr_D[15:0], 2'b00};
  assign br_pc  = PC_D + 32'd4 + br_off;
  assign j_pc   = {PC_D[31:28], instr_D[25:0], 2'b00};
  assign PC8_D  = PC_D + 32'd8;

  always_comb begin
    next_pc = seq_pc;
    unique case (1'b1)
      PC_sel == 3'b001: next_pc = br_pc;
      PC_sel == 3'b010: next_pc = j_pc;
      PC_sel == 3'b011: next_pc = rs_D;
      PC_sel == 3'b100: next_pc = bw ? br_pc : seq_pc;
      default:          next_pc = seq_pc;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_next;

  // Flag follows the PC it describes, so compute it on the next PC.
  assign adel_next = (next_pc[1:0] != 2'b00)
                  || (next_pc < 32'h0000_3000)
                  || (next_pc > 32'h0000_6FFC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      adel_F <= 1'b0;
    end else if (!stall) begin
      adel_F <= adel_next;
    end
  end

  assign nop_D = flush | adel_F;
`else
  assign adel_F = 1'b0;
  assign nop_D  = flush;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      PC_F    <= RESET_PC;
      instr_D <= 32'h0;
      PC_D    <= 32'h0;
    end else if (!stall) begin
      PC_F    <= next_pc;
      instr_D <= nop_D ? 32'h0 : instr_F;
      PC_D    <= PC_F;
    end
  end

endmodule
